// File: rtl/cam_match_encoder.sv
// rtl/cam_match_encoder.sv - serialises a CAM match-line vector into ascending hit addresses.
// Optional: define CAM_ENC_COUNT_EN to add count_o (population count of the accepted vector).
module cam_match_encoder #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         match_valid_i,
  output logic                         match_ready_o,
  input  logic [(1<<ADDR_WIDTH)-1:0]   match_i,
  output logic                         addr_valid_o,
  input  logic                         addr_ready_i,
  output logic [ADDR_WIDTH-1:0]        addr_o,
  output logic                         addr_last_o,
  output logic                         miss_o
`ifdef CAM_ENC_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]          count_o
`endif
);

  localparam int CAM_DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                 state_q, state_d;
  logic [CAM_DEPTH-1:0]   pend_q, pend_d;
  logic                   miss_q, miss_d;
  logic [CAM_DEPTH-1:0]   pend_rest;
  logic [ADDR_WIDTH-1:0]  lsb_idx;
  logic                   pend_single;
  logic                   emit;
  logic                   last;

`ifdef CAM_ENC_COUNT_EN
  logic [ADDR_WIDTH:0]    count_q, count_d;
  logic [ADDR_WIDTH:0]    match_pop;

  always_comb begin
    match_pop = '0;
    for (int i = 0; i < CAM_DEPTH; i++) begin
      match_pop = match_pop + (ADDR_WIDTH+1)'(match_i[i]);
    end
  end
`endif

  // pend with its lowest set bit cleared; zero means exactly one bit remains.
  assign pend_rest   = pend_q & (pend_q - CAM_DEPTH'(1));
  assign pend_single = (pend_rest == '0);
  assign emit        = (state_q == EMIT);
  assign last        = miss_q | pend_single;

  always_comb begin
    lsb_idx = '0;
    for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
      if (pend_q[i]) lsb_idx = ADDR_WIDTH'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    miss_d  = miss_q;
`ifdef CAM_ENC_COUNT_EN
    count_d = count_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (match_valid_i) begin
          pend_d  = match_i;
          miss_d  = (match_i == '0);
          state_d = EMIT;
`ifdef CAM_ENC_COUNT_EN
          count_d = match_pop;
`endif
        end
      end
      EMIT: begin
        if (addr_ready_i) begin
          if (last) begin
            pend_d  = '0;
            miss_d  = 1'b0;
            state_d = IDLE;
`ifdef CAM_ENC_COUNT_EN
            count_d = '0;
`endif
          end else begin
            pend_d = pend_rest;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      miss_q  <= 1'b0;
`ifdef CAM_ENC_COUNT_EN
      count_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      miss_q  <= miss_d;
`ifdef CAM_ENC_COUNT_EN
      count_q <= count_d;
`endif
    end
  end

  // Outputs depend only on registered state.
  always_comb begin
    match_ready_o = ~emit;
    addr_valid_o  = emit;
    miss_o        = emit & miss_q;
    addr_last_o   = emit & last;
    addr_o        = (emit && !miss_q) ? lsb_idx : '0;
  end

`ifdef CAM_ENC_COUNT_EN
  assign count_o = count_q;
`endif

endmodule

// File: tb/tb_cam_match_encoder.sv
// tb/tb_cam_match_encoder.sv - randomized self-checking bench for cam_match_encoder.
module tb_cam_match_encoder;

  localparam int AW = 5;
  localparam int D  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          match_valid_i;
  logic          match_ready_o;
  logic [D-1:0]  match_i;
  logic          addr_valid_o;
  logic          addr_ready_i;
  logic [AW-1:0] addr_o;
  logic          addr_last_o;
  logic          miss_o;
`ifdef CAM_ENC_COUNT_EN
  logic [AW:0]   count_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cam_match_encoder #(.ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .match_valid_i (match_valid_i),
    .match_ready_o (match_ready_o),
    .match_i       (match_i),
    .addr_valid_o  (addr_valid_o),
    .addr_ready_i  (addr_ready_i),
    .addr_o        (addr_o),
    .addr_last_o   (addr_last_o),
    .miss_o        (miss_o)
`ifdef CAM_ENC_COUNT_EN
    ,
    .count_o       (count_o)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ready"}, 32'(match_ready_o), 1);
    check_eq({tag, "_valid"}, 32'(addr_valid_o), 0);
    check_eq({tag, "_addr"},  32'(addr_o), 0);
    check_eq({tag, "_last"},  32'(addr_last_o), 0);
    check_eq({tag, "_miss"},  32'(miss_o), 0);
`ifdef CAM_ENC_COUNT_EN
    check_eq({tag, "_count"}, 32'(count_o), 0);
`endif
  endtask

  // Reference: the ascending list of hit indices, or a single miss beat.
  task automatic run_vector(input logic [D-1:0] vec, input int ready_pct, input int stall_cycles);
    int q[$];
    int pop;
    int cyc;
    int stall;
    logic is_miss;
    logic [AW-1:0] held;
    q = {};
    for (int i = 0; i < D; i++) if (vec[i]) q.push_back(i);
    pop = q.size();
    is_miss = (pop == 0);
    if (is_miss) q.push_back(0);

    cyc = 0;
    while (!match_ready_o && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!match_ready_o) check_eq("accept_timeout", 0, 1);
    match_valid_i = 1'b1;
    match_i       = vec;
    @(negedge clk);
    match_valid_i = 1'b0;
    match_i       = D'({$urandom, $urandom});

    stall = 0;
    held  = '0;
    cyc   = 0;
    while (q.size() > 0 && cyc < 4000) begin
      if (stall < stall_cycles) begin
        addr_ready_i = 1'b0;
        if (stall == 1) begin
          match_valid_i = 1'b1;
          match_i       = D'(32'h0000_00F0);
        end else begin
          match_valid_i = 1'b0;
        end
        if (stall > 0) check_eq("hold_addr", 32'(addr_o), 32'(held));
        held = addr_o;
        stall++;
      end else begin
        match_valid_i = 1'b0;
        addr_ready_i  = ($urandom_range(99) < ready_pct);
      end
      check_eq("beat_valid", 32'(addr_valid_o), 1);
      check_eq("beat_mready", 32'(match_ready_o), 0);
      check_eq("beat_addr", 32'(addr_o), 32'(q[0]));
      check_eq("beat_last", 32'(addr_last_o), 32'(q.size() == 1));
      check_eq("beat_miss", 32'(miss_o), 32'(is_miss));
`ifdef CAM_ENC_COUNT_EN
      check_eq("beat_count", 32'(count_o), 32'(pop));
`endif
      if (addr_ready_i) void'(q.pop_front());
      @(negedge clk);
      cyc++;
    end
    if (q.size() > 0) check_eq("beat_timeout", 32'(q.size()), 0);
    addr_ready_i = 1'b0;
    check_idle("after_last");
    if (stall_cycles > 0) begin
      @(negedge clk);
      check_idle("ignored_pulse");
    end
  endtask

  initial begin
    logic [D-1:0] v;
    rst           = 1'b1;
    match_valid_i = 1'b0;
    match_i       = '0;
    addr_ready_i  = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    run_vector(D'(32'h0000_0010), 100, 0);
    run_vector(D'(32'h8000_0005), 100, 0);
    run_vector('0, 100, 0);
    run_vector(D'(32'h0000_0006), 100, 3);
    run_vector(D'(32'h8000_0000), 100, 0);
    run_vector('1, 50, 0);

    // Reset in the middle of a burst drops the remaining beats at once.
    match_valid_i = 1'b1;
    match_i       = '1;
    @(negedge clk);
    match_valid_i = 1'b0;
    addr_ready_i  = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_idle("async_reset");
    @(negedge clk);
    rst          = 1'b0;
    addr_ready_i = 1'b0;
    @(negedge clk);
    check_idle("after_async_reset");
    run_vector(D'(32'h0000_0010), 100, 0);

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(3))
        0: v = D'({$urandom, $urandom});
        1: v = D'(1) << $urandom_range(D - 1);
        2: v = D'({$urandom, $urandom}) & D'({$urandom, $urandom}) & D'({$urandom, $urandom});
        default: v = '0;
      endcase
      run_vector(v, $urandom_range(30, 100), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
